// File: rtl/vecmul_pkg.sv
// Shared definitions for the vecmul datapath and its issue controller.
// FP32 constants, sequencer state encoding and default datapath geometry.
package vecmul_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  localparam int VM_VSIZE = 4;
  localparam int VM_LAT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, head visible combinationally (zero-latency read), write lands next cycle.
// No internal flow control: pushes while full and pops while empty are dropped.
module sync_fifo #(
  parameter int width = 33,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign pop_data = mem[rd_ptr[aw-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[aw-1:0]] <= push_data;
  end

endmodule

// File: rtl/vecmul_issue_ctrl.sv
// Job sequencer feeding vecmul: issues operand rows, tags results lat cycles later into a FIFO.
// Operand issue is credit-gated so the result FIFO can absorb every in-flight row under res_ready=0.
module vecmul_issue_ctrl
  import vecmul_pkg::*;
#(
  parameter int vsize      = VM_VSIZE,
  parameter int lat        = VM_LAT,
  parameter int fifo_depth = 16,
  parameter int rows_w     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [rows_w-1:0]     cmd_rows,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [32*vsize-1:0]   op_a,
  input  logic [32*vsize-1:0]   op_b,
  output logic [32*vsize-1:0]   vm_in1,
  output logic [32*vsize-1:0]   vm_in2,
  input  logic [31:0]           vm_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [31:0]           res_data,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done
);

  localparam int                cred_w   = $clog2(fifo_depth + 1);
  localparam logic [cred_w-1:0] cred_max = cred_w'(fifo_depth);

  state_t             state, state_nxt;
  logic [rows_w-1:0]  remaining;
  logic [cred_w-1:0]  credits;
  logic [lat-1:0]     tag_vld;
  logic [lat-1:0]     tag_last;
  logic               zero_done;
  logic               issue, last_issue, pop, cmd_go, cmd_zero;
  logic               fifo_full, fifo_empty;
  logic [32:0]        fifo_head;

  assign issue      = op_valid && op_ready;
  assign last_issue = issue && (remaining == rows_w'(1));
  assign pop        = res_valid && res_ready;
  assign cmd_go     = cmd_valid && cmd_ready && (cmd_rows != '0);
  assign cmd_zero   = cmd_valid && cmd_ready && (cmd_rows == '0);

  always_comb begin
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE:  cmd_ready = 1'b1;
      ST_RUN: begin
        busy     = 1'b1;
        op_ready = (credits != '0);
      end
      ST_DRAIN: busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_go) state_nxt = ST_RUN;
      ST_RUN:   if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && fifo_head[32]) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign done = zero_done || ((state == ST_DRAIN) && pop && fifo_head[32]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      credits   <= cred_max;
      tag_vld   <= '0;
      tag_last  <= '0;
      zero_done <= 1'b0;
      vm_in1    <= '0;
      vm_in2    <= '0;
    end else begin
      state     <= state_nxt;
      zero_done <= cmd_zero;
      if (cmd_go)     remaining <= cmd_rows;
      else if (issue) remaining <= remaining - 1'b1;
      // A credit stands for one FIFO slot reserved by a row still inside vecmul or the FIFO.
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
      tag_vld  <= (tag_vld << 1) | lat'(issue);
      tag_last <= (tag_last << 1) | lat'(last_issue);
      vm_in1   <= issue ? op_a : {vsize{FP_ZERO}};
      vm_in2   <= issue ? op_b : {vsize{FP_ZERO}};
    end
  end

  sync_fifo #(
    .width (33),
    .depth (fifo_depth)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_vld[lat-1]),
    .push_data ({tag_last[lat-1], vm_result}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign res_valid = !fifo_empty;
  assign res_data  = fifo_empty ? 32'h0 : fifo_head[31:0];
  assign res_last  = !fifo_empty && fifo_head[32];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(tag_vld[lat-1] && fifo_full))
        else $error("vecmul_issue_ctrl: result fifo written while full");
      assert (credits <= cred_max)
        else $error("vecmul_issue_ctrl: credit counter above fifo depth");
    end
  end

endmodule

// File: tb/tb_vecmul_issue_ctrl.sv
// Bench for vecmul_issue_ctrl: a behavioural vecmul (integer-valued FP32 dot product, lat-cycle delay)
// plus a scoreboard of expected results in issue order.
module tb_vecmul_issue_ctrl;
  import vecmul_pkg::*;

  localparam int VS    = 4;
  localparam int LAT   = 8;
  localparam int DEPTH = 16;
  localparam int RW    = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid, cmd_ready;
  logic [RW-1:0]   cmd_rows;
  logic            op_valid, op_ready;
  logic [32*VS-1:0] op_a, op_b, vm_in1, vm_in2;
  logic [31:0]     vm_result;
  logic            res_valid, res_ready, res_last, busy, done;
  logic [31:0]     res_data;

  vecmul_issue_ctrl #(.vsize(VS), .lat(LAT), .fifo_depth(DEPTH), .rows_w(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .vm_in1(vm_in1), .vm_in2(vm_in2), .vm_result(vm_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  function automatic int fp2int(input logic [31:0] f);
    logic [23:0] m;
    int e;
    if (f[30:0] == 31'h0) return 0;
    e = int'(f[30:23]);
    m = {1'b1, f[22:0]};
    return int'(m >> (150 - e));
  endfunction

  function automatic logic [31:0] int2fp(input int v);
    int p;
    logic [31:0] sh;
    if (v == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 31; i++) if (v[i]) p = i;
    sh = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), sh[22:0]};
  endfunction

  function automatic logic [31:0] dot(input logic [32*VS-1:0] a, input logic [32*VS-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < VS; i++) s += fp2int(a[32*i +: 32]) * fp2int(b[32*i +: 32]);
    return int2fp(s);
  endfunction

  function automatic logic [32*VS-1:0] rand_row();
    logic [32*VS-1:0] r;
    for (int i = 0; i < VS; i++) r[32*i +: 32] = int2fp(int'($urandom_range(15)));
    return r;
  endfunction

  // Behavioural vecmul: lat-1 stages after the registered vm_in, sampled by the DUT at the lat-th edge.
  logic [31:0] stg [LAT-1];
  always @(posedge clk) begin
    stg[0] <= dot(vm_in1, vm_in2);
    for (int i = 1; i < LAT - 1; i++) stg[i] <= stg[i-1];
  end
  assign vm_result = stg[LAT-2];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [32:0] exp_q [$];
  int issue_cyc [$];
  int pop_cyc [$];
  int job_rows   = 0;
  int job_issued = 0;
  int done_cnt   = 0;

  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n) begin
      if (op_valid && op_ready) begin
        job_issued++;
        exp_q.push_back({job_issued == job_rows, dot(op_a, op_b)});
        issue_cyc.push_back(cyc);
      end
      if (res_valid && res_ready) begin
        pop_cyc.push_back(cyc);
        chk("result_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res_data", res_data, e[31:0]);
          chk("res_last", res_last, e[32]);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_job(input int rows);
    job_rows   = rows;
    job_issued = 0;
    exp_q.delete();
    issue_cyc.delete();
    pop_cyc.delete();
    cmd_rows  = RW'(rows);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_job(input int rows, input int bound, input int pv, input int pr);
    int d0;
    d0 = done_cnt;
    start_job(rows);
    for (int i = 0; i < bound && done_cnt == d0; i++) begin
      op_valid  = ($urandom_range(99) < pv);
      res_ready = ($urandom_range(99) < pr);
      op_a = rand_row();
      op_b = rand_row();
      tick();
    end
    op_valid  = 1'b0;
    res_ready = 1'b0;
    chk("job_done", done_cnt - d0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_cnt, d0, rows;
    bit found, stray;
    cmd_valid = 1'b0; cmd_rows = '0; op_valid = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_vm_in1", vm_in1, 0);
    chk("rst_vm_in2", vm_in2, 0);
    chk("rst_res_data", res_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single row: {1,2,3,4} . {1,1,1,1} = 10.0
    start_job(1);
    op_a = {int2fp(4), int2fp(3), int2fp(2), int2fp(1)};
    op_b = {4{FP_ONE}};
    op_valid  = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("single_op_ready", op_ready, 1);
    tick();
    op_valid = 1'b0;
    lat_cnt = 0;
    found = 1'b0;
    for (int k = 0; k < LAT + 4 && !found; k++) begin
      @(negedge clk);
      if (res_valid) found = 1'b1;
      else begin
        lat_cnt++;
        tick();
      end
    end
    chk("single_found", found, 1);
    chk("single_latency", lat_cnt, LAT);
    chk("single_data", res_data, 32'h4120_0000);
    chk("single_last", res_last, 1);
    chk("single_done", done, 1);
    tick();
    @(negedge clk);
    chk("single_done_pulse", done, 0);
    chk("single_busy", busy, 0);
    tick();

    // Throughput: 8 back-to-back rows
    run_job(8, 100, 100, 100);
    chk("tp_issues", issue_cyc.size(), 8);
    chk("tp_pops", pop_cyc.size(), 8);
    if (issue_cyc.size() == 8) chk("tp_issue_span", issue_cyc[7] - issue_cyc[0], 7);
    if (pop_cyc.size() == 8) chk("tp_pop_span", pop_cyc[7] - pop_cyc[0], 7);
    @(negedge clk);
    chk("tp_busy", busy, 0);
    tick();

    // Backpressure: 32 rows, no reads, credits must stop issue at fifo depth
    res_ready = 1'b0;
    start_job(32);
    op_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op_a = rand_row();
      op_b = rand_row();
      tick();
    end
    chk("bp_issues", issue_cyc.size(), DEPTH);
    @(negedge clk);
    chk("bp_op_ready", op_ready, 0);
    chk("bp_res_valid", res_valid, 1);
    chk("bp_no_pop", pop_cyc.size(), 0);
    // Credit boundary: single pop reopens exactly one issue slot
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    chk("cred_op_ready_up", op_ready, 1);
    tick();
    @(negedge clk);
    chk("cred_op_ready_down", op_ready, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("cred_issues", issue_cyc.size(), DEPTH + 1);
    res_ready = 1'b1;
    d0 = done_cnt;
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      op_a = rand_row();
      op_b = rand_row();
      tick();
    end
    op_valid  = 1'b0;
    res_ready = 1'b0;
    chk("bp_done", done_cnt - d0, 1);
    chk("bp_all_issued", issue_cyc.size(), 32);
    chk("bp_all_popped", pop_cyc.size(), 32);

    // Zero-length job
    op_valid = 1'b1;
    d0 = done_cnt;
    start_job(0);
    @(negedge clk);
    chk("zl_done", done, 1);
    chk("zl_busy", busy, 0);
    tick();
    @(negedge clk);
    chk("zl_done_pulse", done, 0);
    chk("zl_cmd_ready", cmd_ready, 1);
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      stray = stray | res_valid | busy;
    end
    chk("zl_quiet", stray, 0);
    chk("zl_no_issue", issue_cyc.size(), 0);
    op_valid = 1'b0;
    tick();

    // Randomized traffic with random valid/ready
    for (int j = 0; j < 3; j++) begin
      rows = int'($urandom_range(10, 30));
      run_job(rows, 3000, 70, 50);
      chk("rand_pops", pop_cyc.size(), rows);
      chk("rand_drained", exp_q.size(), 0);
      tick();
    end

    // Reset mid-job after 5 of 10 issues
    res_ready = 1'b1;
    start_job(10);
    op_valid = 1'b1;
    for (int i = 0; i < 50 && issue_cyc.size() < 5; i++) begin
      op_a = rand_row();
      op_b = rand_row();
      tick();
    end
    chk("mid_issues", issue_cyc.size(), 5);
    rst_n = 1'b0;
    #1;
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_op_ready", op_ready, 0);
    chk("mid_busy", busy, 0);
    chk("mid_res_valid", res_valid, 0);
    chk("mid_vm_in1", vm_in1, 0);
    chk("mid_vm_in2", vm_in2, 0);
    exp_q.delete();
    op_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < LAT + 5; i++) begin
      @(negedge clk);
      stray = stray | res_valid | busy;
      tick();
    end
    chk("mid_no_stray", stray, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
